// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, mode constants and helpers for the LED sequencer
package led_pkg;

    typedef enum logic [1:0] {
        LED_IDLE = 2'd0,
        LED_ON   = 2'd1,
        LED_GAP  = 2'd2
    } led_state_t;

    localparam logic MODE_STRETCH = 1'b0;
    localparam logic MODE_COUNT   = 1'b1;

    // Ceiling log2 for elaboration-time width calculations
    function automatic int led_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_chan.sv
// rtl/led_chan.sv - one LED channel: edge detect, flash/gap FSM, pending-blink counter
module led_chan
    import led_pkg::*;
#(
    parameter int ON_TICKS   = 40,
    parameter int OFF_TICKS  = 40,
    parameter int PEND_W     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic trig,
    input  logic mode,
    output logic led,
    output logic busy
);

    localparam int TW = led_clog2(((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) + 1);
    localparam logic [TW-1:0]     ON_LD    = TW'(ON_TICKS);
    localparam logic [TW-1:0]     OFF_LD   = TW'(OFF_TICKS);
    localparam logic [TW-1:0]     TCNT_ONE = TW'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic              LIT_LVL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    led_state_t        state, state_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [PEND_W-1:0] pend, pend_n;
    logic              trig_d;
    logic              edge_w;
    logic              count_w;
    logic              start_w;

    assign edge_w  = trig & ~trig_d;
    assign count_w = (mode == MODE_COUNT);

    // Next-state logic; a GAP that expires with work queued starts the next blink
    // directly so queued blinks repeat with no idle cycle in between
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        pend_n  = pend;
        start_w = 1'b0;
        case (state)
            LED_IDLE: begin
                start_w = edge_w || (pend != '0);
            end
            LED_ON: begin
                if (!count_w && edge_w) begin
                    tcnt_n = ON_LD;
                end else if (tick) begin
                    if (tcnt == TCNT_ONE) begin
                        if (count_w) begin
                            state_n = LED_GAP;
                            tcnt_n  = OFF_LD;
                        end else begin
                            state_n = LED_IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt - TCNT_ONE;
                    end
                end
                if (count_w && edge_w && (pend != PEND_MAX)) begin
                    pend_n = pend + 1'b1;
                end
            end
            LED_GAP: begin
                if (tick && (tcnt == TCNT_ONE)) begin
                    if (count_w && (edge_w || (pend != '0))) begin
                        start_w = 1'b1;
                    end else begin
                        state_n = LED_IDLE;
                    end
                end else begin
                    if (tick) begin
                        tcnt_n = tcnt - TCNT_ONE;
                    end
                    if (count_w && edge_w && (pend != PEND_MAX)) begin
                        pend_n = pend + 1'b1;
                    end
                end
            end
            default: begin
                state_n = LED_IDLE;
            end
        endcase
        // A blink started from the queue consumes one entry unless a new edge refills it
        if (start_w) begin
            state_n = LED_ON;
            tcnt_n  = ON_LD;
            if ((pend != '0) && !edge_w) begin
                pend_n = pend - 1'b1;
            end
        end
        if (!count_w) begin
            pend_n = '0;
        end
    end

    // Channel registers; led and busy are taken from the next state so they track it exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_d <= 1'b0;
            state  <= LED_IDLE;
            tcnt   <= '0;
            pend   <= '0;
            led    <= ~LIT_LVL;
            busy   <= 1'b0;
        end else begin
            trig_d <= trig;
            state  <= state_n;
            tcnt   <= tcnt_n;
            pend   <= pend_n;
            led    <= (state_n == LED_ON) ? LIT_LVL : ~LIT_LVL;
            busy   <= (state_n != LED_IDLE) || (pend_n != '0);
        end
    end

endmodule

// File: rtl/led_multi.sv
// rtl/led_multi.sv - multi-channel LED pulse stretcher / blink sequencer with shared time base
module led_multi
    import led_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CLK_DIV    = 1000,
    parameter int ON_TICKS   = 40,
    parameter int OFF_TICKS  = 40,
    parameter int PEND_W     = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] trig,
    input  logic [NCH-1:0] mode,
    output logic [NCH-1:0] led,
    output logic [NCH-1:0] busy
);

    localparam int DW = (led_clog2(CLK_DIV) < 1) ? 1 : led_clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    // With CLK_DIV=1 the counter sits at 0 = DIV_LAST, so tick is permanently high
    assign tick = (div_cnt == DIV_LAST);

    // Free-running prescaler shared by every channel
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_chan #(
            .ON_TICKS   (ON_TICKS),
            .OFF_TICKS  (OFF_TICKS),
            .PEND_W     (PEND_W),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .trig  (trig[i]),
            .mode  (mode[i]),
            .led   (led[i]),
            .busy  (busy[i])
        );
    end

endmodule

// File: tb/tb_led_multi.sv
// tb/tb_led_multi.sv - randomized and directed self-checking bench for led_multi
module tb_led_multi;

    localparam int NCH  = 4;
    localparam int ON   = 3;
    localparam int OFF  = 2;
    localparam int QMAX = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] trig = '0;
    logic [NCH-1:0] mode = '0;
    logic [NCH-1:0] led, busy, led_inv, busy_inv;
    logic [NCH-1:0] trig_p = '0;
    logic [NCH-1:0] mode_p = '0;
    logic [NCH-1:0] led_p, busy_p;

    always #5 clk = ~clk;

    led_multi #(.NCH(NCH), .CLK_DIV(1), .ON_TICKS(ON), .OFF_TICKS(OFF), .PEND_W(2), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .trig(trig), .mode(mode), .led(led), .busy(busy));

    led_multi #(.NCH(NCH), .CLK_DIV(1), .ON_TICKS(ON), .OFF_TICKS(OFF), .PEND_W(2), .ACTIVE_LOW(0)) dut_inv (
        .clk(clk), .reset(reset), .trig(trig), .mode(mode), .led(led_inv), .busy(busy_inv));

    led_multi #(.NCH(NCH), .CLK_DIV(4), .ON_TICKS(2), .OFF_TICKS(2), .PEND_W(2), .ACTIVE_LOW(1)) dut_pre (
        .clk(clk), .reset(reset), .trig(trig_p), .mode(mode_p), .led(led_p), .busy(busy_p));

    int n_chk = 0;
    int n_fail = 0;

    // Timeline model: stretch = lit until last edge + ON; count = queue of blink periods of ON+OFF
    int             cyc = 0;
    int             lit_end [NCH];
    int             cur_start [NCH];
    int             q [NCH];
    logic           prev [NCH];
    logic [NCH-1:0] exp_lit = '0;
    logic [NCH-1:0] exp_busy = '0;

    task automatic step();
        logic e;
        logic active;
        @(posedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            if (reset) begin
                lit_end[ch]   = -1000;
                cur_start[ch] = -1000;
                q[ch]         = 0;
                prev[ch]      = 1'b0;
                exp_lit[ch]   = 1'b0;
                exp_busy[ch]  = 1'b0;
            end else begin
                e = trig[ch] & ~prev[ch];
                prev[ch] = trig[ch];
                if (!mode[ch]) begin
                    if (e) lit_end[ch] = cyc + ON;
                    exp_lit[ch]  = (cyc < lit_end[ch]);
                    exp_busy[ch] = (cyc < lit_end[ch]);
                end else begin
                    active = (cyc < cur_start[ch] + ON + OFF);
                    if (!active) begin
                        if (q[ch] > 0) begin
                            cur_start[ch] = cyc;
                            q[ch] = q[ch] - 1 + (e ? 1 : 0);
                        end else if (e) begin
                            cur_start[ch] = cyc;
                        end
                    end else if (e && q[ch] < QMAX) begin
                        q[ch] = q[ch] + 1;
                    end
                    exp_lit[ch]  = (cyc >= cur_start[ch]) && (cyc < cur_start[ch] + ON);
                    exp_busy[ch] = (cyc < cur_start[ch] + ON + OFF) || (q[ch] > 0);
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        trig = '0;
        mode = '0;
        for (int i = 0; i < 3; i++) step();
        n_chk++;
        if ({led, busy, led_inv, busy_inv, led_p, busy_p} !== {4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_state led=%b busy=%b led_inv=%b busy_inv=%b led_p=%b busy_p=%b want led=1111 busy=0000 led_inv=0000 busy_inv=0000 led_p=1111 busy_p=0000",
                     led, busy, led_inv, busy_inv, led_p, busy_p);
        end
        reset = 1'b0;
    endtask

    task automatic test_stretch();
        int lit_cnt = 0;
        mode = '0;
        for (int i = 0; i < 12; i++) begin
            trig[0] = (i == 2);
            step();
            if (!led[0]) lit_cnt++;
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL stretch_cycle cyc=%0d got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b", cyc, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
            end
        end
        n_chk++;
        if (lit_cnt !== 3) begin
            n_fail++;
            $display("FAIL stretch_length got %0d want 3", lit_cnt);
        end
    endtask

    task automatic test_retrigger();
        int lit_cnt = 0;
        int flashes = 0;
        logic was_lit = 1'b0;
        mode = '0;
        for (int i = 0; i < 14; i++) begin
            trig[0] = (i == 2) || (i == 4);
            step();
            if (!led[0]) lit_cnt++;
            if (!led[0] && !was_lit) flashes++;
            was_lit = !led[0];
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL retrigger_cycle cyc=%0d got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b", cyc, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
            end
        end
        n_chk++;
        if (lit_cnt !== 5 || flashes !== 1) begin
            n_fail++;
            $display("FAIL retrigger_length got lit=%0d flashes=%0d want lit=5 flashes=1", lit_cnt, flashes);
        end
    endtask

    task automatic test_queued();
        logic [12:0] pat = '0;
        logic        busy_late = 1'b1;
        mode = 4'b0001;
        for (int i = 0; i < 25; i++) begin
            trig[0] = (i == 2) || (i == 4) || (i == 6);
            step();
            if (i >= 2 && i <= 14) pat = {pat[11:0], ~led[0]};
            if (i == 17) busy_late = busy[0];
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL queued_cycle cyc=%0d got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b", cyc, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
            end
        end
        n_chk++;
        if (pat !== 13'b1110011100111 || busy_late !== 1'b0) begin
            n_fail++;
            $display("FAIL queued_pattern got lit=%b busy_after=%b want lit=1110011100111 busy_after=0", pat, busy_late);
        end
        mode = '0;
    endtask

    // Seven edges on ch1; the one at i=14 meets a full queue and is dropped
    task automatic test_saturation();
        int blinks = 0;
        logic was_lit = 1'b0;
        mode = 4'b0010;
        for (int i = 0; i < 45; i++) begin
            trig[1] = (i >= 2) && (i <= 14) && (i % 2 == 0);
            step();
            if (!led[1] && !was_lit) blinks++;
            was_lit = !led[1];
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL saturation_cycle cyc=%0d got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b", cyc, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
            end
        end
        n_chk++;
        if (blinks !== 6 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_blinks got blinks=%0d busy=%b want blinks=6 busy=0", blinks, busy[1]);
        end
        mode = '0;
    endtask

    task automatic test_long_trig();
        int lit_cnt = 0;
        mode = '0;
        for (int i = 0; i < 30; i++) begin
            trig[2] = (i >= 2) && (i < 22);
            step();
            if (!led[2]) lit_cnt++;
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL long_trig_cycle cyc=%0d got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b", cyc, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
            end
        end
        n_chk++;
        if (lit_cnt !== 3) begin
            n_fail++;
            $display("FAIL long_trig_length got %0d want 3", lit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        mode = '0;
        trig = 4'hF;
        step();
        step();
        reset = 1'b1;
        step();
        n_chk++;
        if ({led, busy, led_inv} !== {4'hF, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_mid got led=%b busy=%b led_inv=%b want led=1111 busy=0000 led_inv=0000", led, busy, led_inv);
        end
        reset = 1'b0;
        step();
        n_chk++;
        if ({led, busy, led_inv} !== {4'h0, 4'hF, 4'hF}) begin
            n_fail++;
            $display("FAIL held_trig_after_reset got led=%b busy=%b led_inv=%b want led=0000 busy=1111 led_inv=1111", led, busy, led_inv);
        end
        trig = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_chk++;
            if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_recover cyc=%0d got led=%b busy=%b want led=%b busy=%b", cyc, led, busy, ~exp_lit, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 6; seg++) begin
            mode = 4'($urandom);
            for (int i = 0; i < 240; i++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    trig[ch] = (i < 200) && ($urandom_range(0, 3) == 0);
                end
                step();
                n_chk++;
                if ({led, busy, led_inv, busy_inv} !== {~exp_lit, exp_busy, exp_lit, exp_busy}) begin
                    n_fail++;
                    $display("FAIL random_cycle seg=%0d cyc=%0d mode=%b got led=%b busy=%b led_inv=%b busy_inv=%b want led=%b busy=%b",
                             seg, cyc, mode, led, busy, led_inv, busy_inv, ~exp_lit, exp_busy);
                end
            end
        end
        mode = '0;
    endtask

    // Each flash is triggered 15 cycles after the last, walking the trigger through all four prescaler phases
    task automatic test_prescaler();
        logic [3:0] seen = '0;
        int len;
        mode_p = '0;
        for (int k = 0; k < 4; k++) begin
            len = 0;
            trig_p[0] = 1'b1;
            for (int i = 0; i < 15; i++) begin
                step();
                trig_p[0] = 1'b0;
                if (!led_p[0]) len++;
                n_chk++;
                if (led_p[3:1] !== 3'b111) begin
                    n_fail++;
                    $display("FAIL prescaler_isolation got led_p=%b want led_p[3:1]=111", led_p);
                end
            end
            n_chk++;
            if (len < 5 || len > 8 || busy_p[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL prescaler_length k=%0d got len=%0d busy=%b want len 5..8 busy=0", k, len, busy_p[0]);
            end else begin
                seen[len-5] = 1'b1;
            end
        end
        n_chk++;
        if (seen !== 4'hF) begin
            n_fail++;
            $display("FAIL prescaler_phases got lengths_seen=%b want 1111", seen);
        end
    endtask

    initial begin
        test_reset();
        test_stretch();
        test_retrigger();
        test_queued();
        test_saturation();
        test_long_trig();
        test_reset_mid();
        test_random();
        test_prescaler();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
